// File: rtl/line_assembler.sv
// line_assembler: packs an accepted character stream into a line buffer.
// A line ends on TERM_CHAR or when the buffer fills. The packed line is then
// held on a valid/ready handshake until the consumer takes it. BS_CHAR removes
// the last stored character, and 8'h00 is dropped.
module line_assembler #(
  parameter int             MAX_CHARS = 100,
  parameter logic [7:0]     TERM_CHAR = 8'h0A,
  parameter logic [7:0]     BS_CHAR   = 8'h08,
  parameter int             LEN_W     = 7
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               char_in,
  input  logic                     char_valid,
  output logic                     char_ready,
  output logic [8*MAX_CHARS-1:0]   message,
  output logic [LEN_W-1:0]         msg_len,
  output logic                     msg_truncated,
  output logic                     msg_valid,
  input  logic                     msg_ready
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_CHARS);

  typedef enum logic {COLLECT, DELIVER} state_e;

  state_e                   state_q, state_d;
  logic [8*MAX_CHARS-1:0]   msg_q, msg_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic                     trunc_q, trunc_d;
  logic                     char_ready_q, msg_valid_q;

  logic                     accept;
  logic                     wr_en, clr_en;
  logic [LEN_W-1:0]         len_inc, len_dec;

  assign accept  = char_valid && (state_q == COLLECT);
  assign len_inc = len_q + LEN_W'(1);
  assign len_dec = len_q - LEN_W'(1);

  // Next-state for the line buffer and the handshake state.
  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    len_d   = len_q;
    trunc_d = trunc_q;
    wr_en   = 1'b0;
    clr_en  = 1'b0;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          if (char_in == TERM_CHAR) begin
            state_d = DELIVER;
            trunc_d = 1'b0;
          end else if (char_in == BS_CHAR) begin
            // Backspace on an empty line is silently dropped.
            if (len_q != '0) begin
              clr_en = 1'b1;
              len_d  = len_dec;
            end
          end else if (char_in != 8'h00) begin
            wr_en = 1'b1;
            len_d = len_inc;
            // A full buffer closes the line without a terminator.
            if (len_inc == MAX_LEN) begin
              state_d = DELIVER;
              trunc_d = 1'b1;
            end
          end
        end
      end
      DELIVER: begin
        if (msg_ready) begin
          state_d = COLLECT;
          msg_d   = '0;
          len_d   = '0;
          trunc_d = 1'b0;
        end
      end
      default: state_d = COLLECT;
    endcase
    // Byte writes and clears are indexed by the current count. Every slot
    // above the count is already zero, so the "unused bytes read 0" rule
    // holds without needing a separate mask.
    for (int k = 0; k < MAX_CHARS; k++) begin
      if (wr_en && (LEN_W'(k) == len_q))
        msg_d[8*k +: 8] = char_in;
      if (clr_en && (LEN_W'(k) == len_dec))
        msg_d[8*k +: 8] = 8'h00;
    end
  end

  // State, buffer and handshake flags are registered; the flags are decoded from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= COLLECT;
      msg_q        <= '0;
      len_q        <= '0;
      trunc_q      <= 1'b0;
      char_ready_q <= 1'b1;
      msg_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      msg_q        <= msg_d;
      len_q        <= len_d;
      trunc_q      <= trunc_d;
      char_ready_q <= (state_d == COLLECT);
      msg_valid_q  <= (state_d == DELIVER);
    end
  end

  assign char_ready    = char_ready_q;
  assign msg_valid     = msg_valid_q;
  assign message       = msg_q;
  assign msg_len       = len_q;
  assign msg_truncated = trunc_q;

endmodule

// File: tb/tb_line_assembler.sv
// Bench for line_assembler. It uses table-driven edit sequences,
// hand-written corner sequences, and a random character stream.
// The random stream is checked against a queue-based line model.
module tb_line_assembler;

  localparam int MAXC = 100;
  localparam int W    = 8 * MAXC;

  logic           clock = 1'b0;
  logic           reset;
  logic [7:0]     char_in;
  logic           char_valid;
  logic           char_ready;
  logic [W-1:0]   message;
  logic [6:0]     msg_len;
  logic           msg_truncated;
  logic           msg_valid;
  logic           msg_ready;

  int n_cmp = 0;
  int n_bad = 0;

  line_assembler #(.MAX_CHARS(MAXC), .TERM_CHAR(8'h0A), .BS_CHAR(8'h08), .LEN_W(7)) dut (
    .clock(clock), .reset(reset), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .message(message), .msg_len(msg_len),
    .msg_truncated(msg_truncated), .msg_valid(msg_valid), .msg_ready(msg_ready)
  );

  always #5 clock = ~clock;

  // ---- reference model: current line as a byte queue, plus a pending delivery
  byte unsigned line[$];
  bit           pend;
  logic [W-1:0] pend_msg;
  int           pend_len;
  bit           pend_trunc;

  function automatic logic [W-1:0] pack_line();
    logic [W-1:0] m = '0;
    foreach (line[i]) m[8*i +: 8] = line[i];
    return m;
  endfunction

  task automatic model_char(input byte unsigned c);
    if (c == 8'h0A) begin
      pend = 1; pend_msg = pack_line(); pend_len = line.size(); pend_trunc = 0;
      line.delete();
    end else if (c == 8'h08) begin
      if (line.size() > 0) void'(line.pop_back());
    end else if (c != 8'h00) begin
      line.push_back(c);
      if (line.size() == MAXC) begin
        pend = 1; pend_msg = pack_line(); pend_len = MAXC; pend_trunc = 1;
        line.delete();
      end
    end
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the source idle. Presents c and waits for
  // char_ready (bounded), lets one posedge accept it, and returns at the next negedge.
  task automatic send(input byte unsigned c);
    int n = 0;
    char_in = c; char_valid = 1'b1;
    while (!char_ready && n < 50) begin @(negedge clock); n++; end
    if (!char_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: char_ready stuck at 0 expected 1");
    end
    @(posedge clock);
    @(negedge clock);
    char_valid = 1'b0;
    model_char(c);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"},   W'(msg_valid),     W'(0));
    chk({tag, "_ready"},   W'(char_ready),    W'(1));
    chk({tag, "_len"},     W'(msg_len),       W'(line.size()));
    chk({tag, "_msg"},     message,           pack_line());
    chk({tag, "_trunc"},   W'(msg_truncated), W'(0));
  endtask

  // Checks the presented line against the model.
  // It holds msg_ready low for `hold` cycles, then takes the line and checks the clear.
  task automatic consume(input string tag, input int hold);
    chk({tag, "_dvalid"}, W'(msg_valid),     W'(1));
    chk({tag, "_dready"}, W'(char_ready),    W'(0));
    chk({tag, "_dmsg"},   message,           pend_msg);
    chk({tag, "_dlen"},   W'(msg_len),       W'(pend_len));
    chk({tag, "_dtrunc"}, W'(msg_truncated), W'(pend_trunc));
    for (int i = 0; i < hold; i++) @(negedge clock);
    if (hold > 0) begin
      chk({tag, "_hmsg"},   message,        pend_msg);
      chk({tag, "_hvalid"}, W'(msg_valid),  W'(1));
    end
    msg_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    msg_ready = 1'b0;
    pend = 0;
    chk_idle({tag, "_clr"});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    line.delete(); pend = 0;
  endtask

  typedef struct {
    byte unsigned c;
    int           exp_len;
    bit           exp_valid;
  } vec_t;

  vec_t vecs[$];
  logic [W-1:0] hold_msg;

  initial begin
    reset = 1'b1; char_in = '0; char_valid = 1'b0; msg_ready = 1'b0;
    pend = 0; line.delete();
    @(negedge clock);
    do_reset();
    chk_idle("reset");

    // "Hi\n": one-cycle latency, byte order, upper bytes zero
    send(8'h48); send(8'h69); send(8'h0A);
    chk("hi_lo16", W'(message[15:0]), W'(16'h6948));
    chk("hi_upper", message >> 16, '0);
    consume("hi", 0);

    // table-driven edit sequences: {char, expected msg_len, expected msg_valid}
    vecs = '{
      '{8'h61, 1, 0}, '{8'h62, 2, 0}, '{8'h63, 3, 0}, '{8'h08, 2, 0},
      '{8'h64, 3, 0}, '{8'h0A, 3, 1},
      '{8'h08, 0, 0}, '{8'h00, 0, 0}, '{8'h78, 1, 0}, '{8'h00, 1, 0},
      '{8'h08, 0, 0}, '{8'h08, 0, 0}, '{8'h79, 1, 0}, '{8'h0A, 1, 1},
      '{8'h0A, 0, 1}
    };
    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].c);
      chk($sformatf("tbl%0d_len", i),   W'(msg_len),   W'(vecs[i].exp_len));
      chk($sformatf("tbl%0d_valid", i), W'(msg_valid), W'(vecs[i].exp_valid));
      if (i == 5) chk("abcd_msg", W'(message[23:0]), W'(24'h646261));
      if (vecs[i].exp_valid) consume($sformatf("tbl%0d", i), 0);
    end

    // full buffer: 100 x 'A' closes the line with the truncated flag
    for (int i = 0; i < MAXC; i++) begin
      if (i == MAXC - 1) chk("full_pre_valid", W'(msg_valid), W'(0));
      send(8'h41);
    end
    chk("full_len",   W'(msg_len),       W'(100));
    chk("full_trunc", W'(msg_truncated), W'(1));
    chk("full_msg",   message,           {MAXC{8'h41}});

    // stall in DELIVER with the source pushing: nothing accepted, outputs hold
    hold_msg = message;
    char_in = 8'h5A; char_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("stall_ready", W'(char_ready), W'(0));
      chk("stall_msg",   message,        hold_msg);
      chk("stall_len",   W'(msg_len),    W'(100));
    end
    char_valid = 1'b0;
    consume("full", 0);

    // reset mid-line
    for (int i = 0; i < 5; i++) send(8'h30 + 8'(i));
    chk("mid_len", W'(msg_len), W'(5));
    do_reset();
    chk_idle("rst_mid");
    // reset during DELIVER
    send(8'h51); send(8'h0A);
    chk("rstd_valid", W'(msg_valid), W'(1));
    do_reset();
    chk_idle("rst_dlv");

    // random stream against the model
    for (int i = 0; i < 2500; i++) begin
      int r = $urandom_range(0, 99);
      byte unsigned c;
      if (r < 3)       c = 8'h0A;
      else if (r < 12) c = 8'h08;
      else if (r < 16) c = 8'h00;
      else             c = 8'($urandom_range(32, 126));
      send(c);
      if (pend) consume("rnd", $urandom_range(0, 3));
      else if (i % 7 == 0) chk_idle("rnd");
      else chk("rnd_len", W'(msg_len), W'(line.size()));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
